// File: rtl/user_ram_pkg.sv
// Shared encodings and defaults for the user RAM arbiter.
package user_ram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_ACC = 1'b1
  } grant_t;

  localparam int unsigned DEF_WORDS     = 256;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0300_2000;

endpackage

// File: rtl/user_ram_arbiter_rr_arb2.sv
// Two-input round-robin picker. On a tie the side that did not win last
// time is granted; last_grant only moves when the caller commits a grant.
module rr_arb2
  import user_ram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   req_cpu,
  input  logic   req_acc,
  input  logic   update_en,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  // Pick a winner and compute the next last_grant.
  always_comb begin
    gnt_valid    = req_cpu | req_acc;
    gnt          = GNT_CPU;
    last_grant_d = last_grant_q;
    if (req_cpu && req_acc) begin
      gnt = (last_grant_q == GNT_ACC) ? GNT_CPU : GNT_ACC;
    end else if (req_acc) begin
      gnt = GNT_ACC;
    end
    if (update_en && gnt_valid) begin
      last_grant_d = gnt;
    end
  end

  // last_grant register; reset favours the CPU on the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GNT_ACC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/user_ram_arbiter.sv
// Shares the single-port user RAM between the CPU iomem bus and the
// accelerator port. Each access runs IDLE -> ACCESS -> RESP.
// Handshake: a requester holds valid (and its address/data) until it sees
// its one-cycle ready pulse; rdata is meaningful only while ready is high,
// and a request is never re-accepted in the cycle its ready is high.
module user_ram_arbiter
  import user_ram_pkg::*;
#(
  parameter int unsigned WORDS     = DEF_WORDS,
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_valid,
  input  logic [3:0]           cpu_wstrb,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_sel,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  input  logic                 acc_valid,
  input  logic                 acc_we,
  input  logic [ADDR_BITS-1:0] acc_addr,
  input  logic [31:0]          acc_wdata,
  output logic                 acc_ready,
  output logic [31:0]          acc_rdata,
  output logic [3:0]           ram_wen,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata,
  output logic [1:0]           dbg_state
);

  // 33-bit window bounds so the upper limit cannot overflow.
  localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * WORDS);

  state_t                 state_q, state_d;
  grant_t                 grant_q, grant_d;
  logic [3:0]             ram_wen_q, ram_wen_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]            ram_wdata_q, ram_wdata_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic                   acc_ready_q, acc_ready_d;
  logic [31:0]            cpu_rdata_q, cpu_rdata_d;
  logic [31:0]            acc_rdata_q, acc_rdata_d;

  logic [31:0]            cpu_off;
  logic [ADDR_BITS-1:0]   cpu_idx;
  logic                   cpu_req;
  logic                   acc_req;
  logic                   arb_update;
  logic                   arb_valid;
  grant_t                 arb_gnt;

  // Address decode and pending-request qualification.
  always_comb begin
    cpu_sel = cpu_valid && ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    cpu_off = cpu_addr - BASE_ADDR;
    cpu_idx = ADDR_BITS'(cpu_off >> 2);
    cpu_req = cpu_sel && !cpu_ready_q;
    acc_req = acc_valid && !acc_ready_q;
  end

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_cpu   (cpu_req),
    .req_acc   (acc_req),
    .update_en (arb_update),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  // Next-state and datapath: grant in IDLE, strobe RAM for one cycle, respond.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ram_wen_d   = 4'h0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    cpu_ready_d = 1'b0;
    acc_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    acc_rdata_d = acc_rdata_q;
    arb_update  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          grant_d    = arb_gnt;
          state_d    = ACCESS;
          if (arb_gnt == GNT_CPU) begin
            ram_addr_d  = cpu_idx;
            ram_wdata_d = cpu_wdata;
            ram_wen_d   = cpu_wstrb;
          end else begin
            ram_addr_d  = acc_addr;
            ram_wdata_d = acc_wdata;
            ram_wen_d   = {4{acc_we}};
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (grant_q == GNT_CPU) begin
          cpu_ready_d = 1'b1;
          cpu_rdata_d = ram_rdata;
        end else begin
          acc_ready_d = 1'b1;
          acc_rdata_d = ram_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_CPU;
      ram_wen_q   <= 4'h0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'h0;
      cpu_ready_q <= 1'b0;
      acc_ready_q <= 1'b0;
      cpu_rdata_q <= 32'h0;
      acc_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      acc_ready_q <= acc_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      acc_rdata_q <= acc_rdata_d;
    end
  end

  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_ready = cpu_ready_q;
  assign acc_ready = acc_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign acc_rdata = acc_rdata_q;
  assign dbg_state = state_q;

endmodule
